// File: rtl/tone_capture_if.sv
// tone_capture_if: groups the tone-capture control and result signals.
//   enable    : measurement enable level (driven by master)
//   pwm_in    : tone line under measurement, asynchronous to clk (driven by master)
//   period    : cycles between the last two accepted rising edges
//   high_time : cycles from rising to falling edge for the reported period
//   valid     : one-cycle strobe, period/high_time update in the same cycle
//   silent    : level, 1 when no valid tone is being measured
interface tone_capture_if #(
  parameter int unsigned CNT_W = 32
);
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             silent;

  modport master (
    output enable,
    output pwm_in,
    input  period,
    input  high_time,
    input  valid,
    input  silent
  );

  modport slave (
    input  enable,
    input  pwm_in,
    output period,
    output high_time,
    output valid,
    output silent
  );
endinterface

// File: rtl/tone_capture.sv
// tone_capture: measures period and high time of a square wave on pwm_in.
//   clk   : system clock (single domain)
//   reset : asynchronous active-low reset
//   bus   : tone_capture_if slave (enable/pwm_in in; period/high_time/valid/silent out)
// Input path is a 2-FF synchronizer, a DEBOUNCE-sample glitch filter and a registered
// edge detector, giving a constant DEBOUNCE+3 cycle pin-to-strobe latency for both edges.
module tone_capture #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned TIMEOUT  = 32'd1_000_000
) (
  input  logic           clk,
  input  logic           reset,
  tone_capture_if.slave  bus
);

  localparam int unsigned      DebW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DebW-1:0]  DebLast    = DebW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWaitRise, StMeasure} state_e;

  // Input conditioning
  logic            sync1_q, sync2_q;
  logic            f_q, f_d, f_prev_q;
  logic [DebW-1:0] deb_q, deb_d;
  logic            rise_q, fall_q;

  always_comb begin
    f_d   = f_q;
    deb_d = '0;
    // Count consecutive disagreeing samples; any agreement restarts the count.
    if (sync2_q != f_q) begin
      if (deb_q == DebLast) begin
        f_d = sync2_q;
      end else begin
        deb_d = deb_q + DebW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      f_q      <= 1'b0;
      deb_q    <= '0;
      f_prev_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= bus.pwm_in;
      sync2_q  <= sync1_q;
      f_q      <= f_d;
      deb_q    <= deb_d;
      f_prev_q <= f_q;
      rise_q   <= f_q & ~f_prev_q;
      fall_q   <= ~f_q & f_prev_q;
    end
  end

  // Measurement FSM
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic             seen_fall_q, seen_fall_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             silent_q, silent_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = rise_q ? CNT_W'(1) :
                  (cnt_q == TimeoutVal) ? cnt_q : cnt_q + CNT_W'(1);
    hi_lat_d    = fall_q ? cnt_q : hi_lat_q;
    seen_fall_d = seen_fall_q | fall_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    silent_d    = silent_q;

    if (!bus.enable) begin
      // Disable beats a coincident rise strobe; last results are kept.
      state_d     = StIdle;
      silent_d    = 1'b1;
      cnt_d       = '0;
      hi_lat_d    = '0;
      seen_fall_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d       = '0;
          hi_lat_d    = '0;
          seen_fall_d = 1'b0;
          silent_d    = 1'b1;
          state_d     = StWaitRise;
        end
        StWaitRise: begin
          if (rise_q) begin
            seen_fall_d = 1'b0;
            state_d     = StMeasure;
          end
        end
        StMeasure: begin
          // Timeout has priority: a rise in the saturated cycle would exceed the range.
          if (cnt_q == TimeoutVal) begin
            silent_d = 1'b1;
            period_d = '0;
            high_d   = '0;
            state_d  = StWaitRise;
          end else if (rise_q) begin
            seen_fall_d = 1'b0;
            if (seen_fall_q) begin
              period_d = cnt_q;
              high_d   = hi_lat_q;
              valid_d  = 1'b1;
              silent_d = 1'b0;
            end else begin
              // No fall since the previous rise: the period is meaningless, drop it.
              hi_lat_d = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      seen_fall_q <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      silent_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      seen_fall_q <= seen_fall_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      silent_q    <= silent_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.silent    = silent_q;

endmodule

// File: tb/tb_tone_capture.sv
// Directed bench for tone_capture with DEBOUNCE=4, TIMEOUT=5000, input synchronous to clk.
// Pin changes are applied 1 time unit after a rising edge; a pin rise at cycle c yields
// valid visible at cycle c+DEBOUNCE+4.
module tb_tone_capture;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DEB   = 4;
  localparam int unsigned TMO   = 5000;
  localparam int          LAT   = DEB + 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  tone_capture_if #(.CNT_W(CNT_W)) bus ();

  tone_capture #(
    .CNT_W    (CNT_W),
    .DEBOUNCE (DEB),
    .TIMEOUT  (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Log of valid strobes and pin rise cycles
  int          v_cyc[$];
  logic [31:0] v_per[$];
  logic [31:0] v_hi[$];
  int          r_cyc[$];

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_per.push_back(bus.period);
      v_hi.push_back(bus.high_time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pwm_in = lvl;
      tick();
    end
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      r_cyc.push_back(cyc);
      drive(1'b1, hi);
      drive(1'b0, per - hi);
    end
  endtask

  task automatic clear_logs();
    v_cyc.delete();
    v_per.delete();
    v_hi.delete();
    r_cyc.delete();
  endtask

  task automatic test_reset();
    int errs = 0;
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.pwm_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.pwm_in = ((i / 5) % 2) == 1;
      tick();
      total++;
      if (bus.period !== 32'd0 || bus.high_time !== 32'd0 || bus.valid !== 1'b0 ||
          bus.silent !== 1'b1) begin
        bad++;
        errs++;
        if (errs < 4)
          $display("FAIL reset_hold: got per=%0d hi=%0d v=%b s=%b want 0 0 0 1",
                   bus.period, bus.high_time, bus.valid, bus.silent);
      end
    end
    drive(1'b0, 10);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_logs();
    drive(1'b0, 20);
    wave(1000, 500, 4);
    total++;
    if (v_cyc.size() != 3) begin
      bad++;
      $display("FAIL basic_count: got %0d valids want 3", v_cyc.size());
    end
    for (int i = 0; i < 3 && i < v_cyc.size(); i++) begin
      total++;
      if (v_cyc[i] != r_cyc[i+1] + LAT || v_per[i] !== 32'd1000 || v_hi[i] !== 32'd500) begin
        bad++;
        $display("FAIL basic_valid%0d: got cyc=%0d per=%0d hi=%0d want cyc=%0d per=1000 hi=500",
                 i, v_cyc[i], v_per[i], v_hi[i], r_cyc[i+1] + LAT);
      end
    end
    total++;
    if (bus.silent !== 1'b0) begin
      bad++;
      $display("FAIL basic_silent: got %b want 0", bus.silent);
    end
  endtask

  task automatic test_duty();
    logic [31:0] exp_hi [3];
    exp_hi[0] = 32'd500;
    exp_hi[1] = 32'd250;
    exp_hi[2] = 32'd250;
    clear_logs();
    wave(1000, 250, 3);
    total++;
    if (v_cyc.size() != 3) begin
      bad++;
      $display("FAIL duty_count: got %0d valids want 3", v_cyc.size());
    end
    for (int i = 0; i < 3 && i < v_cyc.size(); i++) begin
      total++;
      if (v_cyc[i] != r_cyc[i] + LAT || v_per[i] !== 32'd1000 || v_hi[i] !== exp_hi[i]) begin
        bad++;
        $display("FAIL duty_valid%0d: got cyc=%0d per=%0d hi=%0d want cyc=%0d per=1000 hi=%0d",
                 i, v_cyc[i], v_per[i], v_hi[i], r_cyc[i] + LAT, exp_hi[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int last_v;
    int n = 0;
    last_v = (v_cyc.size() > 0) ? v_cyc[v_cyc.size()-1] : cyc;
    bus.pwm_in = 1'b0;
    while (bus.silent !== 1'b1 && n < 6000) begin
      tick();
      n++;
    end
    total++;
    if (bus.silent !== 1'b1 || cyc - last_v != int'(TMO)) begin
      bad++;
      $display("FAIL timeout_delay: got silent=%b after %0d cycles want silent=1 after %0d",
               bus.silent, cyc - last_v, TMO);
    end
    total++;
    if (bus.period !== 32'd0 || bus.high_time !== 32'd0) begin
      bad++;
      $display("FAIL timeout_clear: got per=%0d hi=%0d want 0 0", bus.period, bus.high_time);
    end
    clear_logs();
    wave(1000, 500, 2);
    total++;
    if (v_cyc.size() != 1 || v_cyc[0] != r_cyc[1] + LAT || v_per[0] !== 32'd1000 ||
        v_hi[0] !== 32'd500) begin
      bad++;
      $display("FAIL timeout_restart: got %0d valids (first cyc=%0d) want 1 at cyc=%0d",
               v_cyc.size(), (v_cyc.size() > 0) ? v_cyc[0] : -1, r_cyc[1] + LAT);
    end
  endtask

  task automatic test_glitch();
    int g;
    bus.enable = 1'b0;
    drive(1'b0, 2);
    bus.enable = 1'b1;
    tick();
    clear_logs();
    drive(1'b0, 20);
    drive(1'b1, 2);
    drive(1'b0, 20);
    drive(1'b1, 3);
    drive(1'b0, 20);
    total++;
    if (v_cyc.size() != 0 || bus.silent !== 1'b1) begin
      bad++;
      $display("FAIL glitch_reject: got %0d valids silent=%b want 0 valids silent=1",
               v_cyc.size(), bus.silent);
    end
    // A 4-cycle pulse is the first accepted rise; the next rise 1000 later completes it.
    g = cyc;
    drive(1'b1, 4);
    drive(1'b0, 996);
    drive(1'b1, 500);
    drive(1'b0, 500);
    total++;
    if (v_cyc.size() != 1 || v_cyc[0] != g + 1000 + LAT || v_per[0] !== 32'd1000 ||
        v_hi[0] !== 32'd4) begin
      bad++;
      $display("FAIL glitch_accept4: got %0d valids per=%0d hi=%0d want 1 valid per=1000 hi=4",
               v_cyc.size(), (v_per.size() > 0) ? v_per[0] : 0, (v_hi.size() > 0) ? v_hi[0] : 0);
    end
  endtask

  task automatic test_reset_mid();
    total++;
    if (bus.period !== 32'd1000) begin
      bad++;
      $display("FAIL midreset_pre: got per=%0d want 1000", bus.period);
    end
    drive(1'b1, 300);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (bus.period !== 32'd0 || bus.high_time !== 32'd0 || bus.valid !== 1'b0 ||
        bus.silent !== 1'b1) begin
      bad++;
      $display("FAIL midreset_async: got per=%0d hi=%0d v=%b s=%b want 0 0 0 1",
               bus.period, bus.high_time, bus.valid, bus.silent);
    end
    drive(1'b0, 4);
    reset = 1'b1;
    clear_logs();
    drive(1'b0, 20);
    wave(1000, 500, 2);
    total++;
    if (v_cyc.size() != 1 || v_cyc[0] != r_cyc[1] + LAT || v_per[0] !== 32'd1000 ||
        v_hi[0] !== 32'd500) begin
      bad++;
      $display("FAIL midreset_restart: got %0d valids (first cyc=%0d) want 1 at cyc=%0d",
               v_cyc.size(), (v_cyc.size() > 0) ? v_cyc[0] : -1, r_cyc[1] + LAT);
    end
  endtask

  task automatic test_enable_drop();
    total++;
    if (bus.silent !== 1'b0) begin
      bad++;
      $display("FAIL endrop_pre: got silent=%b want 0", bus.silent);
    end
    clear_logs();
    // Pin rise now; the rise strobe is high in the cycle after 7 more edges.
    bus.pwm_in = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.enable = 1'b0;
    drive(1'b1, 10);
    total++;
    if (v_cyc.size() != 0 || bus.silent !== 1'b1) begin
      bad++;
      $display("FAIL endrop_novalid: got %0d valids silent=%b want 0 valids silent=1",
               v_cyc.size(), bus.silent);
    end
    total++;
    if (bus.period !== 32'd1000 || bus.high_time !== 32'd500) begin
      bad++;
      $display("FAIL endrop_keep: got per=%0d hi=%0d want 1000 500",
               bus.period, bus.high_time);
    end
    bus.enable = 1'b1;
    drive(1'b0, 5);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    test_reset();
    test_basic();
    test_duty();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_enable_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tone_capture.md
# tone_capture

Measures the tone square wave on the speaker PWM line so the design can self-check what it plays. The line can come from a loopback of the tone output or from an external PWM source. For each full cycle of the input, the block reports:
- the period, in `clk` cycles;
- the high time, in `clk` cycles;
- a one-cycle valid strobe.

It sits next to the speaker tone generator in the top level. Downstream logic turns the counts into frequency and duty.

## Interface
- `CNT_W`, 32: width of the period and high-time counters and outputs.
- `DEBOUNCE`, 4: number of consecutive stable synchronized samples needed to accept a level change (minimum 1).
- `TIMEOUT`, 32'd1_000_000: cycles without a rising edge before the input is declared silent. Must be less than 2^CNT_W − 1.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: measurement enable (level).
- `pwm_in` in 1: tone line under measurement. Asynchronous to `clk`.
- `period` out CNT_W: cycles between the last two accepted rising edges.
- `high_time` out CNT_W: cycles from a rising edge to the following falling edge, for the period being reported.
- `valid` out 1: one-cycle pulse; `period` and `high_time` update in this same cycle.
- `silent` out 1: level; 1 when no valid tone is being measured.

## Operation
- Input path: 2-FF synchronizer (reset value 0), then a glitch filter.
  - The filtered level `f` takes the synchronized value only after that value has differed from `f` for `DEBOUNCE` consecutive cycles.
  - Any shorter pulse is ignored.
  - Rise and fall edge strobes are registered from `f`.
- Counter `cnt` (CNT_W bits):
  - On a rise strobe, load 1.
  - Otherwise increment each cycle, saturating at `TIMEOUT`.
- Falling-edge latch `hi_lat`: on a fall strobe, `hi_lat <= cnt`.
- FSM states: IDLE, WAIT_RISE, MEASURE.
  - IDLE: `cnt` held at 0, `silent=1`. Goes to WAIT_RISE when `enable=1`.
  - WAIT_RISE: on a rise strobe, load `cnt` and go to MEASURE. No `valid` here, because no complete period exists yet.
  - MEASURE, on a rise strobe:
    - `period <= cnt`, `high_time <= hi_lat`, `valid <= 1`, `silent <= 0`;
    - `cnt` reloads to 1;
    - stay in MEASURE.
  - MEASURE, timeout: if `cnt` reaches `TIMEOUT` with no rise, then `silent <= 1`, `period <= 0`, `high_time <= 0`, go to WAIT_RISE.
  - MEASURE, no falling edge: if a rise strobe arrives with no fall strobe since the previous rise (impossible after filtering, but guarded), drop the period. No `valid`, and `hi_lat` is cleared.
  - Any state: `enable=0` goes to IDLE on the next cycle.
    - `silent <= 1`, `valid` forced to 0, counters cleared.
    - `period` and `high_time` keep their last values.
- `valid` is a registered single-cycle pulse, at most one per accepted rising edge.
- Reset values: `period=0`, `high_time=0`, `valid=0`, `silent=1`, FSM in IDLE, synchronizer and filter at 0.
- Reset mid-operation:
  - All state clears immediately (asynchronous).
  - After release, two fresh rising edges are needed before the next `valid`.

## Timing
- Pin-to-strobe latency is a constant `DEBOUNCE+3` cycles: 2 for the synchronizer, `DEBOUNCE` for the filter, 1 for the edge register.
- Rise and fall see the same latency, so widths are not distorted.
- `valid` and the new `period`/`high_time` appear in the cycle after the rise strobe.
- Measurement rules:
  - Rising edges N cycles apart give `period = N`.
  - High time H gives `high_time = H`.
  - Accuracy is ±1 cycle for asynchronous input; exact for input synchronous to `clk`.
- Timing limits:
  - Minimum measurable high or low phase is `DEBOUNCE` cycles.
  - Maximum measurable period is `TIMEOUT − 1`.
- `silent` rises in the cycle after `cnt` reaches `TIMEOUT`, i.e. `TIMEOUT` cycles after the last accepted rise.
- A rise strobe and `enable` falling in the same cycle: `enable` wins. No `valid`, go to IDLE.

## Test plan
Bench parameters: `DEBOUNCE=4`, `TIMEOUT=5000`, input synchronous to `clk`.
1. Reset check:
   - Stimulus: hold `reset=0`, toggle `pwm_in`.
   - Response: `period=0`, `high_time=0`, `valid=0`, `silent=1` throughout.
2. Basic measurement:
   - Stimulus: `enable=1`; square wave with period 1000 and high time 500.
   - Response: no `valid` on the first rise. First `valid` arrives `DEBOUNCE+4` cycles after the second pin rise, with `period=1000`, `high_time=500`, `silent=0`. After that, `valid` repeats every 1000 cycles.
3. Duty change:
   - Stimulus: switch to period 1000, high time 250.
   - Response: the next `valid` reports `high_time=250`, `period=1000`.
4. Glitch rejection:
   - Stimulus: input steady low; inject 2-cycle and 3-cycle high pulses.
   - Response: no strobes, no `valid`, `silent` stays 1. A 4-cycle pulse is accepted as an edge.
5. Timeout:
   - Stimulus: stop the input (hold low) after a valid period.
   - Response: 5000 cycles after the last accepted rise, `silent=1`, `period=0`, `high_time=0`. On restart, the first `valid` comes only after the second rise.
6. Reset and enable mid-measurement:
   - Stimulus A: drop `reset` midway through a period.
     - Response: outputs go to reset values in the same cycle (asynchronous).
   - Stimulus B: drop `enable` on the same cycle as a rise strobe.
     - Response: no `valid`, `silent=1`, old `period` retained.
